s_axil_register: RTL and testbench

AXI4-Lite slave register file of 16 × 32-bit read/write registers at byte offsets 0x00–0x3C. It is the downstream consumer of the AXI-Lite master BFM: it accepts write address and write data independently, commits with byte strobes, returns write responses, and serves single-beat reads. It is the device under test for the register-file bench and is reusable as a generic control/status register bank.

---
 rtl/s_axil_register_if.sv | 47 ++++
 rtl/s_axil_register.sv | 144 ++++++++++++++
 tb/tb_s_axil_register.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_axil_register_if.sv
// ---------------------------------------------------------------------------
// s_axil_register_if
//   AXI4-Lite bus bundle for the s_axil_register register bank.
//   Signals: AW (AWADDR/AWVALID/AWREADY), W (WDATA/WSTRB/WVALID/WREADY),
//            B (BRESP/BVALID/BREADY), AR (ARADDR/ARVALID/ARREADY),
//            R (RDATA/RRESP/RVALID/RREADY).
//   Modports: master drives addresses/data/VALIDs and response READYs;
//             slave drives the address/data READYs and responses.
// ---------------------------------------------------------------------------
interface s_axil_register_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/s_axil_register.sv
// ---------------------------------------------------------------------------
// s_axil_register
//   AXI4-Lite slave holding 16 x 32-bit read/write registers at byte offsets
//   0x00-0x3C. AW and W are captured independently (either order or same
//   cycle) and committed one edge after both are held, with byte strobes.
//   Addresses with any bit above bit 5 set answer SLVERR and touch nothing.
//   Ports:
//     ACLK    - clock, rising edge
//     ARESET  - asynchronous active-low reset
//     s_axil  - AXI4-Lite slave modport (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module s_axil_register #(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32
) (
  input  logic             ACLK,
  input  logic             ARESET,
  s_axil_register_if.slave s_axil
);
  localparam int NUM_REGS   = 16;
  localparam int STRB_WIDTH = S_AXI_DATA_WIDTH / 8;

  // Write path state
  logic                        aw_full_reg;
  logic [3:0]                  aw_idx_reg;
  logic                        aw_oor_reg;
  logic                        w_full_reg;
  logic [S_AXI_DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_WIDTH-1:0]       w_strb_reg;
  logic                        b_valid_reg;
  logic [1:0]                  b_resp_reg;

  // Read path state
  logic                        r_valid_reg;
  logic [1:0]                  r_resp_reg;
  logic [S_AXI_DATA_WIDTH-1:0] r_data_reg;
  logic [1:0]                  r_resp_next;
  logic [S_AXI_DATA_WIDTH-1:0] r_data_next;

  logic aw_hs, w_hs, ar_hs, commit;
  logic [S_AXI_DATA_WIDTH-1:0] reg_q [NUM_REGS];

  // Byte-lane bits never take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil.AWADDR[1:0], s_axil.ARADDR[1:0]};

  // READYs come only from local flags, never from the peer's VALID.
  assign s_axil.AWREADY = ~aw_full_reg;
  assign s_axil.WREADY  = ~w_full_reg;
  assign s_axil.ARREADY = ~r_valid_reg;
  assign s_axil.BVALID  = b_valid_reg;
  assign s_axil.BRESP   = b_resp_reg;
  assign s_axil.RVALID  = r_valid_reg;
  assign s_axil.RRESP   = r_resp_reg;
  assign s_axil.RDATA   = r_data_reg;

  assign aw_hs  = s_axil.AWVALID & ~aw_full_reg;
  assign w_hs   = s_axil.WVALID & ~w_full_reg;
  assign ar_hs  = s_axil.ARVALID & ~r_valid_reg;
  // A pending B response holds the captured AW/W until it drains.
  assign commit = aw_full_reg & w_full_reg & ~b_valid_reg;

  // AW/W capture and B response
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      aw_full_reg <= 1'b0;
      aw_idx_reg  <= '0;
      aw_oor_reg  <= 1'b0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      b_valid_reg <= 1'b0;
      b_resp_reg  <= 2'b00;
    end else begin
      // aw_hs needs an empty slot and commit a full one, so they never collide.
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_idx_reg  <= s_axil.AWADDR[5:2];
        aw_oor_reg  <= |s_axil.AWADDR[S_AXI_ADDR_WIDTH-1:6];
      end else if (commit) begin
        aw_full_reg <= 1'b0;
      end

      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= s_axil.WDATA;
        w_strb_reg <= s_axil.WSTRB;
      end else if (commit) begin
        w_full_reg <= 1'b0;
      end

      if (commit) begin
        b_valid_reg <= 1'b1;
        b_resp_reg  <= aw_oor_reg ? 2'b10 : 2'b00;
      end else if (b_valid_reg && s_axil.BREADY) begin
        b_valid_reg <= 1'b0;
      end
    end
  end

  // Register bank: one storage word per generate block, byte-strobed update.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [S_AXI_DATA_WIDTH-1:0] word_reg;
    logic                        wr_en;

    assign wr_en = commit & ~aw_oor_reg & (aw_idx_reg == 4'(gi));

    always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
        word_reg <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (w_strb_reg[b]) word_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
        end
      end
    end

    assign reg_q[gi] = word_reg;
  end

  // Read lookup uses the registered bank, so a same-edge commit is not seen.
  always_comb begin
    r_data_next = '0;
    r_resp_next = 2'b10;
    if (~|s_axil.ARADDR[S_AXI_ADDR_WIDTH-1:6]) begin
      r_data_next = reg_q[s_axil.ARADDR[5:2]];
      r_resp_next = 2'b00;
    end
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_valid_reg <= 1'b0;
      r_resp_reg  <= 2'b00;
      r_data_reg  <= '0;
    end else if (ar_hs) begin
      r_valid_reg <= 1'b1;
      r_resp_reg  <= r_resp_next;
      r_data_reg  <= r_data_next;
    end else if (r_valid_reg && s_axil.RREADY) begin
      r_valid_reg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_s_axil_register.sv
// ---------------------------------------------------------------------------
// tb_s_axil_register
//   Self-checking bench for s_axil_register: reset state, sequential fill,
//   AW/W ordering, strobe/error vector table, concurrent read/write, same-edge
//   collision, B backpressure, random traffic and mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_s_axil_register;
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  s_axil_register_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  s_axil_register #(.S_AXI_DATA_WIDTH(32), .S_AXI_ADDR_WIDTH(32)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .s_axil(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array, byte-merged with a strobe mask.
  logic [31:0] model [16];

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    int idx;
    if (addr >= 32'h40) return 2'b10;
    idx = int'(addr / 4);
    mask = 32'h0;
    for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
    model[idx] = (model[idx] & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] addr);
    if (addr >= 32'h40) return 32'h0;
    return model[int'(addr / 4)];
  endfunction

  function automatic logic [1:0] model_rresp(input logic [31:0] addr);
    return (addr >= 32'h40) ? 2'b10 : 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Per-channel results (one write and one read in flight at a time)
  bit          aw_ok, w_ok, b_ok, ar_ok, r_ok;
  logic [1:0]  b_resp_s, r_resp_s;
  logic [31:0] r_data_s;

  task automatic drive_aw(input logic [31:0] addr, input int dly);
    bit rdy;
    repeat (dly) begin @(posedge ACLK); #1; end
    bus.AWADDR = addr; bus.AWVALID = 1'b1; aw_ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      rdy = bus.AWREADY;
      @(posedge ACLK); #1;
      if (rdy) begin aw_ok = 1'b1; break; end
    end
    bus.AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    bit rdy;
    repeat (dly) begin @(posedge ACLK); #1; end
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1; w_ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      rdy = bus.WREADY;
      @(posedge ACLK); #1;
      if (rdy) begin w_ok = 1'b1; break; end
    end
    bus.WVALID = 1'b0;
  endtask

  task automatic drive_b(input int dly);
    bit v; logic [1:0] r;
    repeat (dly) begin @(posedge ACLK); #1; end
    bus.BREADY = 1'b1; b_ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      v = bus.BVALID; r = bus.BRESP;
      @(posedge ACLK); #1;
      if (v) begin b_ok = 1'b1; b_resp_s = r; break; end
    end
    bus.BREADY = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd);
    fork
      drive_aw(addr, awd);
      drive_w(data, strb, wd);
      drive_b(bd);
    join
    check("wr_handshake", 32'(aw_ok & w_ok & b_ok), 32'd1);
    $display("WR addr=%08h data=%08h strb=%b bresp=%b", addr, data, strb, b_resp_s);
  endtask

  // Write with expected BRESP taken from the model (model updated first).
  task automatic write_m(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awd, input int wd, input int bd);
    logic [1:0] exp;
    exp = model_write(addr, data, strb);
    do_write(addr, data, strb, awd, wd, bd);
    check("bresp", 32'(b_resp_s), 32'(exp));
  endtask

  task automatic do_read(input logic [31:0] addr);
    bit rdy, v; logic [31:0] d; logic [1:0] r;
    repeat ($urandom_range(0, 3)) begin @(posedge ACLK); #1; end
    bus.ARADDR = addr; bus.ARVALID = 1'b1; ar_ok = 1'b0; r_ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      rdy = bus.ARREADY;
      @(posedge ACLK); #1;
      if (rdy) begin ar_ok = 1'b1; break; end
    end
    bus.ARVALID = 1'b0;
    repeat ($urandom_range(0, 3)) begin @(posedge ACLK); #1; end
    bus.RREADY = 1'b1;
    for (int n = 0; n < 200; n++) begin
      v = bus.RVALID; d = bus.RDATA; r = bus.RRESP;
      @(posedge ACLK); #1;
      if (v) begin r_ok = 1'b1; r_data_s = d; r_resp_s = r; break; end
    end
    bus.RREADY = 1'b0;
    check("rd_handshake", 32'(ar_ok & r_ok), 32'd1);
    $display("RD addr=%08h data=%08h rresp=%b", addr, r_data_s, r_resp_s);
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp_d,
                            input logic [1:0] exp_r, input string name);
    do_read(addr);
    check({name, "_rdata"}, r_data_s, exp_d);
    check({name, "_rresp"}, 32'(r_resp_s), 32'(exp_r));
  endtask

  task automatic read_model(input logic [31:0] addr, input string name);
    read_check(addr, model_rdata(addr), model_rresp(addr), name);
  endtask

  task automatic step();
    @(posedge ACLK); #1;
  endtask

  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_val, addr;

    // Vectors assume the register contents left by the fill/ordering steps.
    vecs[0] = '{32'h10, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h10, 32'hFFFFFFFF, 2'b00};
    vecs[1] = '{32'h10, 32'h12345678, 4'h5, 2'b00, 32'h10, 32'hFF34FF78, 2'b00};
    vecs[2] = '{32'h10, 32'hDEADBEEF, 4'h0, 2'b00, 32'h10, 32'hFF34FF78, 2'b00};
    vecs[3] = '{32'h40, 32'hBAD0BAD0, 4'hF, 2'b10, 32'h40, 32'h00000000, 2'b10};
    vecs[4] = '{32'h80000000, 32'h11111111, 4'hF, 2'b10, 32'h00, 32'h00000001, 2'b00};
    vecs[5] = '{32'h17, 32'hAABBCCDD, 4'hA, 2'b00, 32'h14, 32'hAA00CC06, 2'b00};
    vecs[6] = '{32'h3C, 32'h80000001, 4'h8, 2'b00, 32'h3F, 32'h80000010, 2'b00};

    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    ARESET = 1'b1;
    #2 ARESET = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b1;
    step();

    // Reset state
    check("rst_awready", 32'(bus.AWREADY), 32'd1);
    check("rst_wready",  32'(bus.WREADY),  32'd1);
    check("rst_arready", 32'(bus.ARREADY), 32'd1);
    check("rst_bvalid",  32'(bus.BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.RVALID),  32'd0);
    check("rst_bresp",   32'(bus.BRESP),   32'd0);
    check("rst_rresp",   32'(bus.RRESP),   32'd0);
    check("rst_rdata",   bus.RDATA,        32'd0);
    for (int i = 0; i < 16; i++) read_check(32'(4 * i), 32'h0, 2'b00, "rst_read");

    // Sequential fill with random channel delays
    for (int i = 0; i < 16; i++)
      write_m(32'(4 * i), 32'(i + 1), 4'hF, $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9));
    for (int i = 0; i < 16; i++) read_check(32'(4 * i), 32'(i + 1), 2'b00, "fill_read");

    // W five cycles ahead of AW for 0x08
    bus.WDATA = 32'hA5A5A5A5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    check("ord1_wready_low", 32'(bus.WREADY), 32'd0);
    repeat (4) step();
    check("ord1_no_commit", 32'(bus.BVALID), 32'd0);
    bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    check("ord1_bvalid_early", 32'(bus.BVALID), 32'd0);
    step();
    check("ord1_bvalid", 32'(bus.BVALID), 32'd1);
    check("ord1_bresp", 32'(bus.BRESP), 32'd0);
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    check("ord1_bdone", 32'(bus.BVALID), 32'd0);
    void'(model_write(32'h08, 32'hA5A5A5A5, 4'hF));

    // AW ahead of W for 0x0C
    bus.AWADDR = 32'h0C; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    check("ord2_awready_low", 32'(bus.AWREADY), 32'd0);
    repeat (2) step();
    bus.WDATA = 32'h0C0C0C0C; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    check("ord2_bvalid_early", 32'(bus.BVALID), 32'd0);
    step();
    check("ord2_bvalid", 32'(bus.BVALID), 32'd1);
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    void'(model_write(32'h0C, 32'h0C0C0C0C, 4'hF));
    read_check(32'h08, 32'hA5A5A5A5, 2'b00, "ord1_read");
    read_check(32'h0C, 32'h0C0C0C0C, 2'b00, "ord2_read");

    // Strobe and error vector table
    for (int v = 0; v < 7; v++) begin
      void'(model_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb));
      do_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb, 0, 1, 0);
      check($sformatf("vec%0d_bresp", v), 32'(b_resp_s), 32'(vecs[v].bresp));
      read_check(vecs[v].raddr, vecs[v].rdata, vecs[v].rresp, $sformatf("vec%0d", v));
    end

    // Concurrent writes to the low half and reads of the high half
    fork
      begin
        for (int i = 0; i < 8; i++)
          write_m(32'(4 * i), $urandom, 4'hF, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      end
      begin
        for (int i = 8; i < 16; i++) read_model(32'(4 * i), "conc_read");
      end
    join
    for (int i = 0; i < 8; i++) read_model(32'(4 * i), "conc_back");

    // Same-edge commit and AR on 0x04 returns the pre-write value
    old_val = model[1];
    bus.AWADDR = 32'h04; bus.WDATA = 32'h7; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 32'h04; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    check("coll_bvalid", 32'(bus.BVALID), 32'd1);
    check("coll_rvalid", 32'(bus.RVALID), 32'd1);
    check("coll_old_rdata", bus.RDATA, old_val);
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    check("coll_rdone", 32'(bus.RVALID), 32'd0);
    void'(model_write(32'h04, 32'h7, 4'hF));
    read_check(32'h04, 32'h7, 2'b00, "coll_new");

    // BREADY held low: next AW/W accepted but not committed
    bus.AWADDR = 32'h18; bus.WDATA = 32'h11112222; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    step();
    check("bp_bvalid", 32'(bus.BVALID), 32'd1);
    bus.AWADDR = 32'h1C; bus.WDATA = 32'h33334444;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("bp_aw_taken", 32'(bus.AWREADY), 32'd0);
    check("bp_w_taken", 32'(bus.WREADY), 32'd0);
    repeat (8) step();
    check("bp_bvalid_held", 32'(bus.BVALID), 32'd1);
    check("bp_bresp_held", 32'(bus.BRESP), 32'd0);
    check("bp_aw_blocked", 32'(bus.AWREADY), 32'd0);
    read_model(32'h1C, "bp_old");
    void'(model_write(32'h18, 32'h11112222, 4'hF));
    bus.BREADY = 1'b1;
    step();
    check("bp_bdrain", 32'(bus.BVALID), 32'd0);
    step();
    check("bp_second_commit", 32'(bus.BVALID), 32'd1);
    step();
    bus.BREADY = 1'b0;
    check("bp_awready_back", 32'(bus.AWREADY), 32'd1);
    void'(model_write(32'h1C, 32'h33334444, 4'hF));
    read_model(32'h18, "bp_r18");
    read_model(32'h1C, "bp_r1c");

    // Random traffic including out-of-range addresses and partial strobes
    for (int n = 0; n < 40; n++) begin
      addr = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        write_m(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      else
        read_model(addr, "rand_read");
    end

    // Reset while a response is pending and an AW is captured
    bus.AWADDR = 32'h20; bus.WDATA = 32'h55AA55AA; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    step();
    check("rmid_bvalid_before", 32'(bus.BVALID), 32'd1);
    bus.AWADDR = 32'h24; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    #2 ARESET = 1'b0;
    #1;
    check("rmid_bvalid_clr", 32'(bus.BVALID), 32'd0);
    check("rmid_awready", 32'(bus.AWREADY), 32'd1);
    check("rmid_wready", 32'(bus.WREADY), 32'd1);
    step();
    ARESET = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    bus.WDATA = 32'h99; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    repeat (2) step();
    check("rmid_no_commit", 32'(bus.BVALID), 32'd0);
    bus.AWADDR = 32'h24; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    step();
    check("rmid_commit", 32'(bus.BVALID), 32'd1);
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    void'(model_write(32'h24, 32'h99, 4'hF));
    for (int i = 0; i < 16; i++) read_model(32'(4 * i), "rmid_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
